// File: rtl/trace_sig_pkg.sv
// Shared types, widths and the signature rotate step for trace_signature_unit.
package trace_sig_pkg;

  localparam int unsigned SIG_W  = 16;
  localparam int unsigned STIM_W = 8;

  localparam logic [STIM_W-1:0] COUNT_FULL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDone  = 2'd1,
    StAcked = 2'd2
  } trace_state_e;

  // Add the scrambled byte into the low byte, then rotate the whole word left by one.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0]  sig,
                                                 input logic [STIM_W-1:0] scr);
    logic [STIM_W-1:0] sum;
    sum = sig[7:0] + scr;
    return {sig[14:8], sum, sig[15]};
  endfunction

endpackage

// File: rtl/trace_scrambler.sv
// Combinational XOR fold of the processor observation buses and the seed into one byte.
module trace_scrambler
  import trace_sig_pkg::*;
(
  input  logic [STIM_W-1:0] i_seed,
  input  logic [7:0]        i_pc,
  input  logic [7:0]        i_ir,
  input  logic [7:0]        i_pm_address,
  input  logic [7:0]        i_from_ps,
  input  logic [7:0]        i_from_id,
  input  logic [7:0]        i_from_cu,
  input  logic [3:0]        i_x0,
  input  logic [3:0]        i_x1,
  input  logic [3:0]        i_y0,
  input  logic [3:0]        i_y1,
  input  logic [3:0]        i_r,
  input  logic [3:0]        i_m,
  input  logic [3:0]        i_o_reg,
  input  logic              i_zero_flag,
  output logic [STIM_W-1:0] o_scrambled
);

  logic [7:0] w_reg_fold;
  logic [7:0] w_bus_fold;

  always_comb begin
    w_reg_fold = {i_m, i_o_reg} ^ {i_x1, i_x0} ^ {i_y1, i_y0} ^ {3'b000, i_zero_flag, i_r};
    w_bus_fold = i_ir ^ i_pc ^ i_pm_address ^ i_from_ps ^ i_from_id ^ i_from_cu;
    o_scrambled = i_seed ^ w_reg_fold ^ w_bus_fold;
  end

endmodule

// File: rtl/trace_signature_unit.sv
// Stimulus counter plus 16-bit signature accumulator; freezes after COUNT_FULL updates
// and hands the result out through a sig_valid/sig_ack handshake.
module trace_signature_unit
  import trace_sig_pkg::*;
#(
  parameter logic [STIM_W-1:0] COUNT_FULL = COUNT_FULL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STIM_W-1:0] seed,
  input  logic [7:0]        pc,
  input  logic [7:0]        ir,
  input  logic [7:0]        pm_address,
  input  logic [7:0]        from_PS,
  input  logic [7:0]        from_ID,
  input  logic [7:0]        from_CU,
  input  logic [3:0]        x0,
  input  logic [3:0]        x1,
  input  logic [3:0]        y0,
  input  logic [3:0]        y1,
  input  logic [3:0]        r,
  input  logic [3:0]        m,
  input  logic [3:0]        o_reg,
  input  logic              zero_flag,
  input  logic              sig_ack,
  output logic [STIM_W-1:0] stimulus,
  output logic [3:0]        i_pins,
  output logic [SIG_W-1:0]  signature,
  output logic              sig_valid,
  output logic              done
);

  trace_state_e      r_state;
  logic [STIM_W-1:0] r_stimulus;
  logic [SIG_W-1:0]  r_signature;
  logic              r_sig_valid;
  logic              r_done;

  logic [STIM_W-1:0] w_scrambled;
  logic [STIM_W-1:0] w_stim_inc;
  logic [SIG_W-1:0]  w_next_sig;
  logic              w_full;

  trace_scrambler u_scrambler (
    .i_seed       (seed),
    .i_pc         (pc),
    .i_ir         (ir),
    .i_pm_address (pm_address),
    .i_from_ps    (from_PS),
    .i_from_id    (from_ID),
    .i_from_cu    (from_CU),
    .i_x0         (x0),
    .i_x1         (x1),
    .i_y0         (y0),
    .i_y1         (y1),
    .i_r          (r),
    .i_m          (m),
    .i_o_reg      (o_reg),
    .i_zero_flag  (zero_flag),
    .o_scrambled  (w_scrambled)
  );

  always_comb begin
    w_full     = (r_stimulus == COUNT_FULL);
    w_stim_inc = r_stimulus + 8'd1;
    w_next_sig = sig_step(r_signature, w_scrambled);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_stimulus  <= '0;
      r_signature <= '0;
      r_sig_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (!w_full) begin
            r_stimulus  <= w_stim_inc;
            r_signature <= w_next_sig;
          end
          // Flags rise on the same edge that makes the counter reach COUNT_FULL.
          if (w_full || (w_stim_inc == COUNT_FULL)) begin
            r_state     <= StDone;
            r_sig_valid <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        StDone: begin
          if (sig_ack) begin
            r_state     <= StAcked;
            r_sig_valid <= 1'b0;
          end
        end
        StAcked: begin
          r_sig_valid <= 1'b0;
          r_done      <= 1'b1;
        end
        default: begin
          r_state     <= StRun;
          r_stimulus  <= '0;
          r_signature <= '0;
          r_sig_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign stimulus  = r_stimulus;
  assign i_pins    = r_stimulus[7:4];
  assign signature = r_signature;
  assign sig_valid = r_sig_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_trace_signature_unit.sv
// Directed self-checking bench for trace_signature_unit with a small signature model.
module tb_trace_signature_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seed = 8'h00;
  logic [7:0]  pc, ir, pm_address, from_ps, from_id, from_cu;
  logic [3:0]  x0, x1, y0, y1, r, m, o_reg;
  logic        zero_flag;
  logic        sig_ack = 1'b0;
  logic [7:0]  stimulus;
  logic [3:0]  i_pins;
  logic [15:0] signature;
  logic        sig_valid;
  logic        done;

  int total = 0;
  int bad   = 0;

  trace_signature_unit dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .pc         (pc),
    .ir         (ir),
    .pm_address (pm_address),
    .from_PS    (from_ps),
    .from_ID    (from_id),
    .from_CU    (from_cu),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .r          (r),
    .m          (m),
    .o_reg      (o_reg),
    .zero_flag  (zero_flag),
    .sig_ack    (sig_ack),
    .stimulus   (stimulus),
    .i_pins     (i_pins),
    .signature  (signature),
    .sig_valid  (sig_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] scr_model();
    return seed ^ {m, o_reg} ^ {x1, x0} ^ {y1, y0} ^ {3'b000, zero_flag, r} ^ ir ^ pc
         ^ pm_address ^ from_ps ^ from_id ^ from_cu;
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [7:0] scr);
    logic [7:0] sum;
    sum = s[7:0] + scr;
    return {s[14:8], sum, s[15]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    {pc, ir, pm_address, from_ps, from_id, from_cu} = '0;
    {x0, x1, y0, y1, r, m, o_reg} = '0;
    zero_flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Deterministic processor-like activity keyed on the stimulus value.
  task automatic set_obs(input logic [7:0] n);
    pc = n; ir = (n * 8'd7) ^ 8'h3C; pm_address = n + 8'h11; from_ps = ~n;
    from_id = {n[3:0], n[7:4]}; from_cu = n * 8'd3;
    x0 = n[3:0]; x1 = n[7:4] ^ 4'h5; y0 = n[6:3]; y1 = ~n[3:0];
    r = n[5:2]; m = n[4:1] ^ 4'hA; o_reg = n[7:4]; zero_flag = (n[2:0] == 3'd0);
  endtask

  task automatic test_reset();
    seed = 8'hFF; sig_ack = 1'b1;
    pc = 8'h12; ir = 8'h34; pm_address = 8'h56; from_ps = 8'h78; from_id = 8'h9A;
    from_cu = 8'hBC; {x0, x1, y0, y1, r, m, o_reg} = 28'h1234567; zero_flag = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    total++; if (stimulus !== 8'h00) begin bad++; $display("FAIL reset_stim got=%h exp=00", stimulus); end
    total++; if (signature !== 16'h0000) begin bad++; $display("FAIL reset_sig got=%h exp=0000", signature); end
    total++; if (sig_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sig_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (i_pins !== 4'h0) begin bad++; $display("FAIL reset_pins got=%h exp=0", i_pins); end
    sig_ack = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_seed_one();
    logic [15:0] exp_sig [9];
    exp_sig = '{16'h0002, 16'h0006, 16'h000E, 16'h001E, 16'h003E, 16'h007E, 16'h00FE,
                16'h01FE, 16'h03FE};
    clear_obs(); seed = 8'h01;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (signature !== exp_sig[k-1]) begin
        bad++; $display("FAIL seed1_sig edge=%0d got=%h exp=%h", k, signature, exp_sig[k-1]);
      end
      total++;
      if (stimulus !== 8'(k)) begin
        bad++; $display("FAIL seed1_stim edge=%0d got=%h exp=%h", k, stimulus, 8'(k));
      end
    end
  endtask

  task automatic test_zero_run();
    logic [7:0] n8;
    clear_obs(); seed = 8'h00;
    do_reset();
    for (int k = 1; k <= 255; k++) begin
      n8 = 8'(k);
      tick();
      total++;
      if (stimulus !== n8 || i_pins !== n8[7:4] || signature !== 16'h0000) begin
        bad++; $display("FAIL zero_run edge=%0d stim=%h pins=%h sig=%h exp stim=%h pins=%h sig=0000",
                        k, stimulus, i_pins, signature, n8, n8[7:4]);
      end
      total++;
      if (sig_valid !== (k == 255) || done !== (k == 255)) begin
        bad++; $display("FAIL zero_flags edge=%0d valid=%b done=%b exp=%b", k, sig_valid, done,
                        (k == 255));
      end
    end
    tick();
    total++;
    if (stimulus !== 8'hFF || signature !== 16'h0000 || sig_valid !== 1'b1) begin
      bad++; $display("FAIL zero_frozen stim=%h sig=%h valid=%b exp FF/0000/1", stimulus,
                      signature, sig_valid);
    end
  endtask

  task automatic test_done_hold_and_ack();
    logic [15:0] exp;
    exp = 16'h0000;
    clear_obs(); seed = 8'h5A;
    do_reset();
    for (int k = 1; k <= 255; k++) begin
      // Ack pulses while running, and on the DONE-entry edge itself, must be ignored.
      sig_ack = ((k % 37) == 0) || (k == 255);
      exp = model_step(exp, scr_model());
      tick();
      total++;
      if (signature !== exp || stimulus !== 8'(k)) begin
        bad++; $display("FAIL ackrun edge=%0d sig=%h stim=%h exp sig=%h stim=%h", k, signature,
                        stimulus, exp, 8'(k));
      end
    end
    sig_ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pc = 8'(i * 5); seed = 8'(i);
      tick();
      total++;
      if (signature !== exp || stimulus !== 8'hFF || sig_valid !== 1'b1 || done !== 1'b1) begin
        bad++; $display("FAIL hold cyc=%0d sig=%h stim=%h valid=%b done=%b exp sig=%h FF 1 1", i,
                        signature, stimulus, sig_valid, done, exp);
      end
    end
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;
    total++;
    if (sig_valid !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL ack_flags valid=%b done=%b exp 0 1", sig_valid, done);
    end
    total++;
    if (signature !== exp || stimulus !== 8'hFF) begin
      bad++; $display("FAIL ack_sig sig=%h stim=%h exp %h FF", signature, stimulus, exp);
    end
    for (int i = 0; i < 6; i++) begin
      sig_ack = i[0];
      tick();
      total++;
      if (sig_valid !== 1'b0 || done !== 1'b1 || signature !== exp) begin
        bad++; $display("FAIL acked_stay cyc=%0d valid=%b done=%b sig=%h exp 0 1 %h", i,
                        sig_valid, done, signature, exp);
      end
    end
    sig_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] exp;
    seed = 8'h33; exp = 16'h0000;
    do_reset();
    for (int k = 1; k <= 99; k++) begin
      set_obs(8'(k - 1));
      tick();
    end
    set_obs(8'd99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (stimulus !== 8'h00 || signature !== 16'h0000 || sig_valid !== 1'b0 || done !== 1'b0
        || i_pins !== 4'h0) begin
      bad++; $display("FAIL midreset stim=%h sig=%h valid=%b done=%b pins=%h exp all zero",
                      stimulus, signature, sig_valid, done, i_pins);
    end
    for (int k = 1; k <= 255; k++) begin
      set_obs(8'(k - 1));
      exp = model_step(exp, scr_model());
      tick();
    end
    total++;
    if (signature !== exp || stimulus !== 8'hFF || sig_valid !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL rerun sig=%h stim=%h valid=%b done=%b exp %h FF 1 1", signature,
                      stimulus, sig_valid, done, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    seed = 8'hAA; exp = 16'h0000;
    do_reset();
    for (int k = 1; k <= 255; k++) begin
      {pc, ir, pm_address, from_ps} = $urandom;
      {from_id, from_cu, x0, x1, y0, y1} = $urandom;
      {r, m, o_reg} = 12'($urandom);
      zero_flag = 1'($urandom);
      exp = model_step(exp, scr_model());
      tick();
    end
    total++;
    if (signature !== exp) begin
      bad++; $display("FAIL random_sig got=%h exp=%h", signature, exp);
    end
    total++;
    if (stimulus !== 8'hFF || sig_valid !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL random_flags stim=%h valid=%b done=%b exp FF 1 1", stimulus,
                      sig_valid, done);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_seed_one();
    test_zero_run();
    test_done_hold_and_ack();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
